// File: rtl/throb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : throb_pkg
// Purpose  : Shared types and constants for the led_throbber channel driver.
// Revision : 1.0 - initial release
// ============================================================================
package throb_pkg;

  // Per-channel operating mode, as written through the config port
  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } throb_mode_t;

  // Direction of the breathing duty ramp
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage : throb_pkg
`default_nettype wire

// File: rtl/throb_channel.sv
`default_nettype none
// ============================================================================
// Module   : throb_channel
// Purpose  : One LED channel: divider, breathing duty/direction, LED state
//            and tick pulse. OFF / ON / BLINK / BREATHE behaviour.
// Options  : THROB_GAMMA_EN - square-law duty mapping for BREATHE
// Revision : 1.0 - initial release
// ============================================================================
module throb_channel
  import throb_pkg::*;
#(
  parameter int          PWM_BITS            = 8,
  parameter int          DIV_BITS            = 24,
  parameter int          DEFAULT_HALF_PERIOD = 6_000_000,
  parameter throb_mode_t RESET_MODE          = MODE_BLINK
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_we,
  input  throb_mode_t         i_mode,
  input  logic [DIV_BITS-1:0] i_half_period,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led,
  output logic                o_tick
);

  localparam logic [PWM_BITS-1:0] c_DUTY_MAX = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] c_DUTY_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam logic [DIV_BITS-1:0] c_DIV_ONE  = {{(DIV_BITS-1){1'b0}}, 1'b1};

  throb_mode_t         r_mode, w_mode_n;
  logic [DIV_BITS-1:0] r_hp,   w_hp_n;
  logic [DIV_BITS-1:0] r_div,  w_div_n;
  logic [PWM_BITS-1:0] r_duty, w_duty_n;
  logic                r_dir,  w_dir_n;
  logic                r_led,  w_led_n;
  logic                r_tick, w_tick_n;
  logic                w_term;
  logic [PWM_BITS-1:0] w_duty_eff;

  assign w_term = (r_div == r_hp);

`ifdef THROB_GAMMA_EN
  // Perceptual square law: keep the upper half of the full-width product
  logic [2*PWM_BITS-1:0] w_duty_sq;
  assign w_duty_sq  = {{PWM_BITS{1'b0}}, r_duty} * {{PWM_BITS{1'b0}}, r_duty};
  assign w_duty_eff = w_duty_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign w_duty_eff = r_duty;
`endif

  // Next-state logic: a config write restarts the channel, otherwise run the mode
  always_comb begin
    w_mode_n = r_mode;
    w_hp_n   = r_hp;
    w_div_n  = r_div;
    w_duty_n = r_duty;
    w_dir_n  = r_dir;
    w_led_n  = r_led;
    w_tick_n = 1'b0;
    if (i_we) begin
      w_mode_n = i_mode;
      w_hp_n   = i_half_period;
      w_div_n  = '0;
      w_duty_n = '0;
      w_dir_n  = DIR_UP;
      w_led_n  = 1'b0;
    end else begin
      case (r_mode)
        MODE_OFF: begin
          w_div_n = '0;
          w_led_n = 1'b0;
        end
        MODE_ON: begin
          w_div_n = '0;
          w_led_n = 1'b1;
        end
        MODE_BLINK: begin
          if (w_term) begin
            w_div_n  = '0;
            w_led_n  = ~r_led;
            w_tick_n = 1'b1;
          end else begin
            w_div_n = r_div + c_DIV_ONE;
          end
        end
        default: begin
          // The LED uses the duty currently held; the ramp step lands next cycle
          w_led_n = (i_pwm_cnt < w_duty_eff);
          if (w_term) begin
            w_div_n = '0;
            if (r_dir == DIR_UP && r_duty == c_DUTY_MAX) begin
              w_dir_n  = DIR_DOWN;
              w_duty_n = c_DUTY_MAX - c_DUTY_ONE;
              w_tick_n = 1'b1;
            end else if (r_dir == DIR_DOWN && r_duty == '0) begin
              w_dir_n  = DIR_UP;
              w_duty_n = c_DUTY_ONE;
              w_tick_n = 1'b1;
            end else if (r_dir == DIR_UP) begin
              w_duty_n = r_duty + c_DUTY_ONE;
            end else begin
              w_duty_n = r_duty - c_DUTY_ONE;
            end
          end else begin
            w_div_n = r_div + c_DIV_ONE;
          end
        end
      endcase
    end
  end

  // Channel state register with asynchronous reset to the power-on configuration
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= RESET_MODE;
      r_hp   <= DIV_BITS'(DEFAULT_HALF_PERIOD);
      r_div  <= '0;
      r_duty <= '0;
      r_dir  <= DIR_UP;
      r_led  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_mode <= w_mode_n;
      r_hp   <= w_hp_n;
      r_div  <= w_div_n;
      r_duty <= w_duty_n;
      r_dir  <= w_dir_n;
      r_led  <= w_led_n;
      r_tick <= w_tick_n;
    end
  end

  assign o_led  = r_led;
  assign o_tick = r_tick;

endmodule : throb_channel
`default_nettype wire

// File: rtl/led_throbber.sv
`default_nettype none
// ============================================================================
// Module   : led_throbber
// Purpose  : Multi-channel LED indicator driver (OFF/ON/BLINK/BREATHE) with a
//            valid/ready config port, bad-channel error pulse and a shared
//            free-running PWM counter.
// Options  : THROB_GAMMA_EN - square-law duty mapping for BREATHE channels
// Revision : 1.0 - initial release
// ============================================================================
module led_throbber
  import throb_pkg::*;
#(
  parameter int NUM_CHAN            = 4,
  parameter int PWM_BITS            = 8,
  parameter int DIV_BITS            = 24,
  parameter int DEFAULT_HALF_PERIOD = 6_000_000,
  parameter int RESET_MODE          = 2
) (
  input  logic                                              clock,
  input  logic                                              reset_n,
  input  logic                                              cfg_valid,
  output logic                                              cfg_ready,
  input  logic [((NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1)-1:0] cfg_chan,
  input  logic [1:0]                                        cfg_mode,
  input  logic [DIV_BITS-1:0]                               cfg_half_period,
  output logic                                              cfg_err,
  output logic [NUM_CHAN-1:0]                               led,
  output logic [NUM_CHAN-1:0]                               tick
);

  localparam int                  c_CHAN_W     = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam throb_mode_t         c_RESET_MODE = throb_mode_t'(RESET_MODE[1:0]);
  localparam logic [PWM_BITS-1:0] c_PWM_ONE    = {{(PWM_BITS-1){1'b0}}, 1'b1};

  logic                r_ready;
  logic                r_err;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_accept;
  logic                w_bad_chan;

  assign w_accept   = cfg_valid && r_ready;
  assign w_bad_chan = (int'(cfg_chan) >= NUM_CHAN);

  // Handshake: ready drops for one cycle after each accept; flag out-of-range channels
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_ready <= ~w_accept;
      r_err   <= w_accept && w_bad_chan;
    end
  end

  // Shared PWM phase counter, free-running and never restarted by config
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + c_PWM_ONE;
    end
  end

  assign cfg_ready = r_ready;
  assign cfg_err   = r_err;

  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
    logic w_we;
    // Out-of-range channel numbers never match any instance, so they write nothing
    assign w_we = w_accept && (cfg_chan == c_CHAN_W'(gi));

    throb_channel #(
      .PWM_BITS            (PWM_BITS),
      .DIV_BITS            (DIV_BITS),
      .DEFAULT_HALF_PERIOD (DEFAULT_HALF_PERIOD),
      .RESET_MODE          (c_RESET_MODE)
    ) u_chan (
      .clock         (clock),
      .reset_n       (reset_n),
      .i_we          (w_we),
      .i_mode        (throb_mode_t'(cfg_mode)),
      .i_half_period (cfg_half_period),
      .i_pwm_cnt     (r_pwm_cnt),
      .o_led         (led[gi]),
      .o_tick        (tick[gi])
    );
  end

endmodule : led_throbber
`default_nettype wire

// File: tb/tb_led_throbber.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_throbber
// Purpose  : Self-checking bench for led_throbber. Each channel is modelled
//            by its elapsed cycles since the last restart; LED level, tick and
//            breathing duty are computed from that count arithmetically.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_throbber;

  localparam int NCH  = 3;
  localparam int PWMB = 4;
  localparam int DIVB = 8;
  localparam int DHP  = 3;
  localparam int PMAX = 15;
  localparam int PPER = 16;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            cfg_valid = 1'b0;
  logic [1:0]      cfg_chan = 2'd0;
  logic [1:0]      cfg_mode = 2'd0;
  logic [DIVB-1:0] cfg_half_period = '0;
  logic            cfg_ready;
  logic            cfg_err;
  logic [NCH-1:0]  led;
  logic [NCH-1:0]  tick;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int             m_mode[NCH];
  int             m_hp[NCH];
  int             m_e[NCH];
  int             m_edges;
  logic           m_ready;
  logic           m_err;
  logic [NCH-1:0] m_led;
  logic [NCH-1:0] m_tick;

  led_throbber #(
    .NUM_CHAN            (NCH),
    .PWM_BITS            (PWMB),
    .DIV_BITS            (DIVB),
    .DEFAULT_HALF_PERIOD (DHP),
    .RESET_MODE          (2)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_chan        (cfg_chan),
    .cfg_mode        (cfg_mode),
    .cfg_half_period (cfg_half_period),
    .cfg_err         (cfg_err),
    .led             (led),
    .tick            (tick)
  );

  always #5 clock = ~clock;

  // Breathing duty after s ramp steps: triangle 0..MAX..0 with period 2*MAX
  function automatic int tri_duty(int s);
    int p;
    p = s % (2 * PMAX);
    return (p <= PMAX) ? p : (2 * PMAX - p);
  endfunction

  function automatic int duty_eff(int d);
`ifdef THROB_GAMMA_EN
    return (d * d) / PPER;
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 2;
      m_hp[c]   = DHP;
      m_e[c]    = 0;
    end
    m_edges = 0;
    m_ready = 1'b1;
    m_err   = 1'b0;
    m_led   = '0;
    m_tick  = '0;
  endtask

  task automatic model_edge(bit v, int ch, int md, int hp);
    int pwm_before;
    bit acc;
    pwm_before = m_edges % PPER;
    acc = v && m_ready;
    m_edges++;
    for (int c = 0; c < NCH; c++) begin
      if (acc && ch == c) begin
        m_mode[c] = md;
        m_hp[c]   = hp;
        m_e[c]    = 0;
        m_led[c]  = 1'b0;
        m_tick[c] = 1'b0;
      end else begin
        int per;
        int e;
        int s;
        m_e[c]++;
        e   = m_e[c];
        per = m_hp[c] + 1;
        s   = e / per;
        case (m_mode[c])
          0: begin m_led[c] = 1'b0; m_tick[c] = 1'b0; end
          1: begin m_led[c] = 1'b1; m_tick[c] = 1'b0; end
          2: begin
            m_led[c]  = (s % 2) == 1;
            m_tick[c] = (e % per) == 0;
          end
          default: begin
            m_led[c]  = pwm_before < duty_eff(tri_duty((e - 1) / per));
            m_tick[c] = ((e % per) == 0) &&
                        (((s % (2 * PMAX)) == PMAX + 1) || ((s % (2 * PMAX)) == 1 && s > 1));
          end
        endcase
      end
    end
    m_err   = acc && (ch >= NCH);
    m_ready = !acc;
  endtask

  task automatic check_outputs(string tag);
    checks++;
    assert (led === m_led) else begin
      failures++;
      $error("FAIL %s led got=%b exp=%b", tag, led, m_led);
    end
    checks++;
    assert (tick === m_tick) else begin
      failures++;
      $error("FAIL %s tick got=%b exp=%b", tag, tick, m_tick);
    end
    checks++;
    assert (cfg_ready === m_ready) else begin
      failures++;
      $error("FAIL %s cfg_ready got=%b exp=%b", tag, cfg_ready, m_ready);
    end
    checks++;
    assert (cfg_err === m_err) else begin
      failures++;
      $error("FAIL %s cfg_err got=%b exp=%b", tag, cfg_err, m_err);
    end
  endtask

  // Drive inputs (at the falling edge), advance one rising edge, then check
  task automatic step(bit v, int ch, int md, int hp, string tag);
    cfg_valid       = v;
    cfg_chan        = 2'(ch);
    cfg_mode        = 2'(md);
    cfg_half_period = DIVB'(hp);
    @(posedge clock);
    model_edge(v, ch, md, hp % 256);
    @(negedge clock);
    check_outputs(tag);
  endtask

  initial begin
    // Power-on reset
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_outputs("reset");
    reset_n = 1'b1;
    model_reset();

    // Default BLINK on all channels: toggle every DHP+1 cycles
    for (int i = 0; i < 12; i++) step(1'b0, 0, 0, 0, "default_blink");

    // Channel 1 to ON; others keep blinking
    step(1'b1, 1, 1, 0, "cfg_on_accept");
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 0, "on_hold");

    // Back-to-back request: second one must wait for ready
    step(1'b1, 2, 0, 0, "b2b_first");
    step(1'b1, 2, 1, 0, "b2b_blocked");
    step(1'b1, 2, 1, 0, "b2b_second");
    step(1'b0, 0, 0, 0, "b2b_idle");

    // Channel 0 BREATHE with fastest ramp: full triangle plus reversal ticks
    step(1'b1, 0, 3, 0, "breathe_cfg");
    for (int i = 0; i < 70; i++) step(1'b0, 0, 0, 0, "breathe_ramp");

    // Out-of-range channel: error pulse, no state change
    step(1'b1, 3, 1, 5, "bad_chan");
    step(1'b0, 0, 0, 0, "bad_chan_after");

    // Restarting with the current mode restarts the channel
    step(1'b1, 0, 3, 0, "rewrite_same");
    for (int i = 0; i < 20; i++) step(1'b0, 0, 0, 0, "rewrite_run");

    // Randomised configuration traffic
    for (int i = 0; i < 2500; i++) begin
      bit v;
      int ch;
      int md;
      int hp;
      v  = ($urandom_range(0, 7) == 0);
      ch = int'($urandom_range(0, 3));
      md = int'($urandom_range(0, 3));
      hp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
      step(v, ch, md, hp, "random");
    end

    // Mid-BREATHE asynchronous reset
    step(1'b1, 0, 3, 0, "pre_reset_cfg");
    for (int i = 0; i < 20; i++) step(1'b0, 0, 0, 0, "pre_reset_run");
    cfg_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(posedge clock);
    @(negedge clock);
    check_outputs("async_reset_held");
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 0, 0, 0, "post_reset_blink");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_led_throbber
`default_nettype wire
